// File: rtl/masked_share_gen.sv
// Sequential 8-share Boolean masking front end: splits a plaintext byte into
// eight shares using seven LFSR mask bytes drawn one per cycle.
module masked_share_gen #(
  parameter logic [31:0] SEED = 32'hACE1_2024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic [31:0] seed_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_shares
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LFSR_W = 32;
  localparam int unsigned CNT_W  = 3;

  localparam logic [CNT_W-1:0] LAST_MASK = 3'd6;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] x_q;
  logic [LFSR_W-1:0] lfsr_q;

  logic              accept_c;
  logic              fill_last_c;
  logic [LFSR_W-1:0] lfsr_step_c;
  logic [LFSR_W-1:0] seed_sel_c;
  logic [DATA_W-1:0] mask_c;

  // Fibonacci LFSR, x^32 + x^22 + x^2 + x + 1
  assign lfsr_step_c = {lfsr_q[LFSR_W-2:0],
                        lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign seed_sel_c  = (seed_in == '0) ? SEED : seed_in;
  assign mask_c      = lfsr_q[DATA_W-1:0];

  // Next-state and handshake decode
  always_comb begin
    state_d     = state_q;
    accept_c    = 1'b0;
    fill_last_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept_c = 1'b1;
          state_d  = FILL;
        end
      end
      FILL: begin
        if (cnt_q == LAST_MASK) begin
          fill_last_c = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_valid && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == OUT);
    end
  end

  // Mask generation datapath; LFSR advances only while filling
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      acc_q      <= '0;
      x_q        <= '0;
      out_shares <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Seed load lands before the first FILL cycle reads the LFSR
          if (seed_load) begin
            lfsr_q <= seed_sel_c;
          end
          if (accept_c) begin
            x_q   <= in_data;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        FILL: begin
          out_shares[{cnt_q, 3'b000} +: DATA_W] <= mask_c;
          acc_q  <= acc_q ^ mask_c;
          lfsr_q <= lfsr_step_c;
          cnt_q  <= cnt_q + 3'd1;
          if (fill_last_c) begin
            // Closing share; plaintext copy is scrubbed once folded in
            out_shares[63:56] <= x_q ^ acc_q ^ mask_c;
            x_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_masked_share_gen.sv
// Directed and randomized checks of masked_share_gen share values, latency,
// stalling, seeding and reset behaviour.
module tb_masked_share_gen;

  localparam logic [31:0] SEED = 32'hACE1_2024;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [31:0] seed_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_shares;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_lfsr;

  masked_share_gen dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_shares (out_shares)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  function automatic logic [7:0] xor_shares(input logic [63:0] s);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) r = r ^ s[8*i +: 8];
    return r;
  endfunction

  // Reference share vector for one transaction; advances the model LFSR
  task automatic model_txn(input logic [7:0] x, output logic [63:0] sh);
    logic [7:0] a;
    a  = 8'h00;
    sh = '0;
    for (int k = 0; k < 7; k++) begin
      sh[8*k +: 8] = m_lfsr[7:0];
      if (k == 6) sh[63:56] = x ^ a ^ m_lfsr[7:0];
      a      = a ^ m_lfsr[7:0];
      m_lfsr = lfsr_step(m_lfsr);
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until out_valid, counting cycles where in_ready was wrongly high
  task automatic wait_ov(input int budget, output int ir_high);
    int n;
    n = 0;
    ir_high = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
      if (in_ready) ir_high++;
    end
    if (!out_valid) check("out_valid_timeout", 64'd0, 64'd1);
  endtask

  logic [63:0] exp_sh;
  logic [63:0] snap;
  int          ir_high;
  int          bad;

  initial begin
    rst = 1'b1; seed_load = 1'b0; seed_in = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready",   64'(in_ready),  64'd1);
    check("rst_out_valid",  64'(out_valid), 64'd0);
    check("rst_out_shares", out_shares,     64'h0);

    // Seed 1 loaded on the same edge as accepting 0xAA
    out_ready = 1'b1;
    seed_load = 1'b1; seed_in = 32'h1;
    in_valid  = 1'b1; in_data = 8'hAA;
    m_lfsr = 32'h1;
    model_txn(8'hAA, exp_sh);
    tick();
    seed_load = 1'b0; in_valid = 1'b0;
    check("t1_in_ready_low", 64'(in_ready), 64'd0);
    repeat (6) tick();
    check("t1_ov_n6",  64'(out_valid), 64'd0);
    check("t1_ir_n6",  64'(in_ready),  64'd0);
    tick();
    check("t1_ov_n7",  64'(out_valid), 64'd1);
    check("t1_shares", out_shares, 64'hE36D_361B_0D06_0301);
    check("t1_model",  out_shares, exp_sh);
    check("t1_xor",    64'(xor_shares(out_shares)), 64'hAA);
    tick();
    check("t1_ov_done", 64'(out_valid), 64'd0);
    check("t1_ir_done", 64'(in_ready),  64'd1);

    // 0x00 without reseeding, then a 20-cycle output stall
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'h00;
    model_txn(8'h00, exp_sh);
    tick();
    in_valid = 1'b0;
    wait_ov(20, ir_high);
    check("t2_ir_low",  64'(ir_high), 64'd0);
    check("t2_share0",  64'(out_shares[7:0]), 64'hDB);
    check("t2_xor",     64'(xor_shares(out_shares)), 64'h00);
    check("t2_model",   out_shares, exp_sh);
    in_valid = 1'b1; in_data = 8'h55;
    snap = out_shares;
    bad  = 0;
    repeat (20) begin
      tick();
      if (out_shares !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check("t2_stall_bad", 64'(bad), 64'd0);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    check("t2_ov_done", 64'(out_valid), 64'd0);
    check("t2_ir_done", 64'(in_ready),  64'd1);

    // Post-stall transaction continues from the frozen LFSR
    in_valid = 1'b1; in_data = 8'h3C;
    model_txn(8'h3C, exp_sh);
    tick();
    in_valid = 1'b0;
    wait_ov(20, ir_high);
    check("t3_model", out_shares, exp_sh);
    tick();

    // seed_in=0 loads the default seed; seed_load during FILL is ignored
    seed_load = 1'b1; seed_in = 32'h0;
    tick();
    seed_load = 1'b0;
    m_lfsr = SEED;
    in_valid = 1'b1; in_data = 8'h5A;
    model_txn(8'h5A, exp_sh);
    tick();
    in_valid  = 1'b0;
    seed_load = 1'b1; seed_in = 32'h1234_5678;
    tick(); tick();
    seed_load = 1'b0;
    wait_ov(20, ir_high);
    check("t4_share0", 64'(out_shares[7:0]), 64'h24);
    check("t4_model",  out_shares, exp_sh);
    check("t4_xor",    64'(xor_shares(out_shares)), 64'h5A);
    tick();

    // Reset at FILL cycle 3 aborts the transaction
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_in_ready",   64'(in_ready),  64'd1);
    check("t5_out_valid",  64'(out_valid), 64'd0);
    check("t5_out_shares", out_shares,     64'h0);
    m_lfsr = SEED;
    in_valid = 1'b1; in_data = 8'hC3;
    model_txn(8'hC3, exp_sh);
    tick();
    in_valid = 1'b0;
    wait_ov(20, ir_high);
    check("t5_share0", 64'(out_shares[7:0]), 64'h24);
    check("t5_xor",    64'(xor_shares(out_shares)), 64'hC3);
    check("t5_model",  out_shares, exp_sh);
    tick();

    // Randomized stream with input and output stalls
    begin
      logic [63:0] exp_q[$];
      logic [7:0]  x_q[$];
      logic [63:0] e;
      logic [7:0]  xv;
      logic        took;
      logic        hs;
      int          sent;
      int          got;
      int          cyc;
      sent = 0; got = 0; cyc = 0;
      in_valid = 1'b0;
      while (got < 1000 && cyc < 40000) begin
        if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_data  = 8'($urandom);
        end
        out_ready = ($urandom_range(0, 2) != 0);
        took = in_valid && in_ready;
        hs   = out_valid && out_ready;
        if (hs) begin
          if (exp_q.size() == 0) begin
            check("reg_spurious_out", 64'd1, 64'd0);
          end else begin
            e  = exp_q.pop_front();
            xv = x_q.pop_front();
            check("reg_xor",    64'(xor_shares(out_shares)), 64'(xv));
            check("reg_shares", out_shares, e);
          end
          got++;
        end
        tick();
        cyc++;
        if (took) begin
          model_txn(in_data, e);
          exp_q.push_back(e);
          x_q.push_back(in_data);
          sent++;
          in_valid = 1'b0;
        end
      end
      check("reg_out_count", 64'(got),  64'd1000);
      check("reg_in_count",  64'(sent), 64'd1000);
      check("reg_leftover",  64'(exp_q.size()), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
